hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Pipeline sequencing controller for the 5-stage ARM-subset core; it sits beside decode and consumes decode-stage fields produced by control_unit.
- Tracks in-flight destination registers and flag writers for EX/MEM/WB and holds the NZCV flag register.
- Evaluates condition codes and resolves branches in ID.
- Drives stall, bubble, flush and freeze to the fetch, decode and execute pipeline registers, and handshakes with data memory.

Parameters:
- REG_ADDR_W, 4, register index width.
- BRANCH_PENALTY, 1, fetch-flush cycles after a taken branch (legal 1..3).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rn  in  REG_ADDR_W  first source register
- id_rm  in  REG_ADDR_W  second source register
- id_uses_rm  in  1  rm is read (low for immediate forms)
- id_rd  in  REG_ADDR_W  destination register
- id_writes_rd  in  1  instruction writes rd
- id_is_load  in  1  load
- id_is_mem  in  1  load or store
- id_is_branch  in  1  branch format
- id_cond  in  4  condition field [31:28]
- id_set_cond  in  1  S bit [20]
- ex_flags  in  4  NZCV from ALU for the instruction in EX
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- flags  out  4  architectural NZCV
- cond_pass  out  1  id_cond true against the current flags
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- id_ex_bubble  out  1  load NOP into ID/EX
- if_flush  out  1  clear IF/ID (wrong-path fetch)
- branch_taken  out  1  load branch target into PC
- freeze  out  1  hold all pipeline registers
- fwd_a  out  2  rn forward select (0 regfile, 1 EX, 2 MEM, 3 WB)
- fwd_b  out  2  rm forward select (same encoding)

Behaviour:
- Reset: all tag valids, flags, and the flush counter go to 0; every output is 0.
- Tag pipeline: EX/MEM/WB tags each hold {valid, rd, writes_rd, is_load, is_mem, set_cond}.
  - On each unfrozen clock, ID→EX, EX→MEM and MEM→WB.
  - A bubbled or killed ID instruction enters EX with valid=0.
  - The WB tag retires.
- Freeze: asserted combinationally when the MEM tag is valid with is_mem=1 and mem_ready=0.
  - While frozen, tags, flags and the flush counter hold, and all other stall/flush outputs are forced to 0.
- Flags: on an unfrozen edge with the EX tag valid and set_cond=1, flags <= ex_flags.
- Flag hazard: an ID instruction with id_cond≠1110 while the EX tag has valid and set_cond set is a hazard.
- cond_pass uses the standard ARM table:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 treated as 0.
- RAW hazard: compare id_rn (always) and id_rm (when id_uses_rm) against each in-flight tag that is valid with writes_rd set.
  - Without the forwarding feature, any match is a hazard.
- Stall: on any hazard with id_valid set, assert pc_stall, if_id_stall and id_ex_bubble, and suppress branch and kill.
- Kill: a non-branch id_valid instruction with cond_pass=0 and no hazard enters EX as a bubble. PC advances normally.
- Branch: id_valid, id_is_branch, cond_pass and no hazard give a 1-cycle branch_taken pulse.
  - The flush counter loads BRANCH_PENALTY.
  - if_flush is asserted while the counter is nonzero; the counter decrements each unfrozen cycle.
  - A second taken branch while the counter is nonzero is impossible (IF/ID is flushed), so no check is needed.
- Priority: freeze > stall > branch/flush > normal.
- Reset asserted mid-operation clears all state immediately (async); the first post-reset cycle has no hazards.

Optional Feature:
- Macro HAZ_FORWARD_EN.
- When defined:
  - fwd_a/fwd_b select the youngest matching writer, with priority EX>MEM>WB.
  - A RAW hazard is raised only when the matching EX tag has is_load (one-cycle load-use stall).
  - A load match in MEM forwards with select 2.
- When undefined: fwd_a/fwd_b are tied to 0 and every RAW match stalls until the producer retires.

Decomposition:
- A shared package holds:
  - the condition-code constants (EQ..AL);
  - the forward-select encoding;
  - the stage-tag struct typedef;
  - the flag bit positions N=3, Z=2, C=1, V=0.
- One natural sub-module is cond_eval: a combinational block from cond and flags to pass, reusable by the execute stage.

Test Plan:
- Reset mid-stream: rst_n low with EX/MEM tags valid → flags=0000, all outputs 0 on the same cycle.
- Back-to-back dependency with add r1 then add r2,r1,r3:
  - Without HAZ_FORWARD_EN → 3 stall cycles, then issue.
  - With HAZ_FORWARD_EN → 0 stalls, fwd_a=1.
- Load-use: ldr r4 then sub r5,r4,r6 with HAZ_FORWARD_EN → exactly 1 bubble, then fwd_a=2.
- Flag hazard: subs giving ex_flags=0100, then beq →
  - 1 stall cycle;
  - flags=0100;
  - cond_pass=1 and branch_taken pulses 1 cycle;
  - if_flush is high BRANCH_PENALTY cycles.
- Condition fail: flags=0000, ID addne (cond 0001) passes; ID addeq (cond 0000) is killed → id_ex_bubble=0, EX tag valid=0, pc_stall=0.
- Memory freeze: str in MEM with mem_ready low for 4 cycles → freeze=1 for 4 cycles, tags and flags unchanged, a pending RAW stall resumes after mem_ready.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer: condition codes, NZCV bit positions,
// forward-select encoding and the in-flight stage tag.
package hazard_sequencer_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   // Wide enough for any supported register index width; narrower indices are zero-extended.
   localparam int TAG_RD_W = 8;

   typedef struct packed {
      logic                valid;
      logic [TAG_RD_W-1:0] rd;
      logic                writes_rd;
      logic                is_load;
      logic                is_mem;
      logic                set_cond;
   } stage_tag_t;

   localparam stage_tag_t TAG_EMPTY = '0;

   function automatic logic tag_writes(input stage_tag_t t, input logic [TAG_RD_W-1:0] r);
      return t.valid & t.writes_rd & (t.rd == r);
   endfunction

   // Youngest producer wins.
   function automatic fwd_sel_e fwd_pick(input logic in_ex, input logic in_mem, input logic in_wb);
      if (in_ex)  return FWD_EX;
      if (in_mem) return FWD_MEM;
      if (in_wb)  return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_sequencer_cond_eval.sv
// ARM condition-code evaluator: purely combinational, cond + NZCV -> pass.
module hazard_sequencer_cond_eval
   import hazard_sequencer_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: in-flight tags, NZCV, hazard stall, kill, branch flush, memory freeze.
// Optional build macro HAZ_FORWARD_EN enables EX/MEM/WB operand forwarding with load-use stalls only.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int REG_ADDR_W     = 4,
   parameter int BRANCH_PENALTY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rn,
   input  logic [REG_ADDR_W-1:0] id_rm,
   input  logic                  id_uses_rm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_writes_rd,
   input  logic                  id_is_load,
   input  logic                  id_is_mem,
   input  logic                  id_is_branch,
   input  logic [3:0]            id_cond,
   input  logic                  id_set_cond,
   input  logic [3:0]            ex_flags,
   input  logic                  mem_ready,
   output logic [3:0]            flags,
   output logic                  cond_pass,
   output logic                  pc_stall,
   output logic                  if_id_stall,
   output logic                  id_ex_bubble,
   output logic                  if_flush,
   output logic                  branch_taken,
   output logic                  freeze,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   localparam logic [1:0] FLUSH_LOAD = 2'(BRANCH_PENALTY);

   stage_tag_t          tag_ex, tag_mem, tag_wb, tag_id;
   logic [1:0]          flush_cnt;
   logic [TAG_RD_W-1:0] rn_w, rm_w, rd_w;
   logic                pass, id_live;
   logic                rn_ex, rn_mem, rn_wb, rm_ex, rm_mem, rm_wb;
   logic                raw_hazard, flag_hazard, hazard, stall, kill, take;
   logic                unused_tag_bits;

   hazard_sequencer_cond_eval u_cond_eval (
      .cond  (id_cond),
      .flags (flags),
      .pass  (pass)
   );

   // Gating with rst_n forces every combinational output low while reset is held,
   // even when decode keeps presenting an instruction.
   assign id_live = id_valid & rst_n;
   assign rn_w    = TAG_RD_W'(id_rn);
   assign rm_w    = TAG_RD_W'(id_rm);
   assign rd_w    = TAG_RD_W'(id_rd);

   assign rn_ex  = tag_writes(tag_ex,  rn_w);
   assign rn_mem = tag_writes(tag_mem, rn_w);
   assign rn_wb  = tag_writes(tag_wb,  rn_w);
   assign rm_ex  = id_uses_rm & tag_writes(tag_ex,  rm_w);
   assign rm_mem = id_uses_rm & tag_writes(tag_mem, rm_w);
   assign rm_wb  = id_uses_rm & tag_writes(tag_wb,  rm_w);

`ifdef HAZ_FORWARD_EN
   // Only a load still in EX has no value to forward yet.
   assign raw_hazard = (rn_ex | rm_ex) & tag_ex.is_load;
   assign fwd_a      = id_live ? fwd_pick(rn_ex, rn_mem, rn_wb) : FWD_RF;
   assign fwd_b      = id_live ? fwd_pick(rm_ex, rm_mem, rm_wb) : FWD_RF;
`else
   assign raw_hazard = rn_ex | rn_mem | rn_wb | rm_ex | rm_mem | rm_wb;
   assign fwd_a      = FWD_RF;
   assign fwd_b      = FWD_RF;
`endif

   // Some tag fields only matter in one build or one stage.
   assign unused_tag_bits = ^{tag_ex.is_load, tag_mem.is_load, tag_mem.set_cond,
                              tag_wb.is_load, tag_wb.is_mem, tag_wb.set_cond};

   assign freeze      = tag_mem.valid & tag_mem.is_mem & ~mem_ready;
   assign flag_hazard = (id_cond != COND_AL) & tag_ex.valid & tag_ex.set_cond;
   assign hazard      = raw_hazard | flag_hazard;
   assign stall       = id_live & hazard;
   assign take        = id_live & id_is_branch & pass & ~hazard;
   assign kill        = id_live & ~id_is_branch & ~pass & ~hazard;
   assign cond_pass   = id_live & pass;

   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_bubble = 1'b0;
      branch_taken = 1'b0;
      if_flush     = 1'b0;
      if (!freeze) begin
         pc_stall     = stall;
         if_id_stall  = stall;
         id_ex_bubble = stall;
         branch_taken = take;
         if_flush     = (flush_cnt != 2'd0);
      end
   end

   // A stalled or killed instruction enters EX as an empty tag.
   always_comb begin
      tag_id = TAG_EMPTY;
      if (id_live && !hazard && !kill) begin
         tag_id.valid     = 1'b1;
         tag_id.rd        = rd_w;
         tag_id.writes_rd = id_writes_rd;
         tag_id.is_load   = id_is_load;
         tag_id.is_mem    = id_is_mem;
         tag_id.set_cond  = id_set_cond;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_ex    <= TAG_EMPTY;
         tag_mem   <= TAG_EMPTY;
         tag_wb    <= TAG_EMPTY;
         flags     <= 4'b0000;
         flush_cnt <= 2'd0;
      end else if (!freeze) begin
         tag_ex  <= tag_id;
         tag_mem <= tag_ex;
         tag_wb  <= tag_mem;
         if (tag_ex.valid && tag_ex.set_cond) flags <= ex_flags;
         if (take)                    flush_cnt <= FLUSH_LOAD;
         else if (flush_cnt != 2'd0)  flush_cnt <= flush_cnt - 2'd1;
      end
   end

endmodule
